// File: rtl/multi_cycle_adder.sv
// Multi-cycle add/subtract: processes CHUNK bits per clock, LSB chunk first.
// Ports: clk_i, rst_ni, clear_i, in_valid_i/in_ready_o, a_i, b_i, cin_i,
//   sub_i, out_valid_o/out_ready_i, sum_o, cout_o, ovf_o.
module multi_cycle_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             cout_q, ovf_q;

  logic             accept;
  logic             last;
  int               off;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  assign accept = (state_q == IDLE) && in_valid_i && !clear_i;
  assign last   = (idx_q == LAST);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; clear overrides every handshake
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (in_valid_i)  state_d = RUN;
        RUN:     if (last)        state_d = DONE;
        DONE:    if (out_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
  end

  // One chunk of the ripple add, selected by the chunk index
  always_comb begin
    off   = int'(idx_q) * CHUNK;
    a_ch  = CHUNK'(a_q >> off);
    b_ch  = CHUNK'(b_q >> off);
    csum  = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    sum_d = (sum_q & ~(MASK << off))
          | (WIDTH'(csum[CHUNK-1:0]) << off);
    // Carry into the MSB is recovered from the MSB sum bit
    ovf_d = a_ch[CHUNK-1] ^ b_ch[CHUNK-1]
          ^ csum[CHUNK-1] ^ csum[CHUNK];
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clear_i) begin
      idx_q   <= '0;
    end else if (accept) begin
      idx_q   <= '0;
      a_q     <= a_i;
      // Subtraction as A + ~B + ~borrow
      b_q     <= sub_i ? ~b_i : b_i;
      carry_q <= sub_i ? ~cin_i : cin_i;
    end else if (state_q == RUN) begin
      sum_q   <= sum_d;
      carry_q <= csum[CHUNK];
      if (last) begin
        idx_q  <= '0;
        cout_q <= csum[CHUNK];
        ovf_q  <= ovf_d;
      end else begin
        idx_q  <= idx_q + 1'b1;
      end
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: doc/multi_cycle_adder.md
MULTI_CYCLE_ADDER -- requirements
Module: multi_cycle_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits added per cycle; legal only when WIDTH % CHUNK == 0 and 1 <= CHUNK <= WIDTH; NCHUNK = WIDTH/CHUNK.
REQ-003 clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 clear_i  input  1  synchronous abort of any operation in progress.
REQ-006 in_valid_i  input  1  operands valid.
REQ-007 in_ready_o  output  1  block can accept operands.
REQ-008 a_i  input  WIDTH  operand A.
REQ-009 b_i  input  WIDTH  operand B.
REQ-010 cin_i  input  1  carry-in (add) / borrow-in (sub).
REQ-011 sub_i  input  1  0 = A+B+cin, 1 = A-B-cin.
REQ-012 out_valid_o  output  1  result valid.
REQ-013 out_ready_i  input  1  consumer accepts result.
REQ-014 sum_o  output  WIDTH  result.
REQ-015 cout_o  output  1  carry-out of final chunk (sub: 1 = no borrow).
REQ-016 ovf_o  output  1  two's-complement signed overflow.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DONE.
REQ-018 in_ready_o SHALL be 1 only in IDLE; out_valid_o SHALL be 1 only in DONE.
REQ-019 Input handshake completes on an edge with in_valid_i && in_ready_o; a_i, b_i, sub_i SHALL be registered; for sub the stored B SHALL be ~b_i.
REQ-020 Carry register at acceptance SHALL be cin_i for add and ~cin_i for sub.
REQ-021 IDLE -> RUN on accepted handshake; chunk index SHALL reset to 0.
REQ-022 Each RUN cycle SHALL add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of stored A and B plus carry register, LSB chunk first, writing the CHUNK-bit sum into the same bit slice of the result register and the chunk carry-out into the carry register.
REQ-023 RUN SHALL last exactly NCHUNK cycles; after the last chunk: RUN -> DONE; out_valid_o first high NCHUNK cycles after the acceptance edge.
REQ-024 On entry to DONE, cout_o SHALL equal the final carry, and ovf_o SHALL equal carry into MSB XOR carry out of MSB.
REQ-025 DONE -> IDLE on edge with out_ready_i = 1; while out_ready_i = 0, sum_o, cout_o, ovf_o SHALL hold stable.
REQ-026 No new operand SHALL be accepted in RUN or DONE; minimum issue interval NCHUNK+2 cycles with out_ready_i tied high.
REQ-027 Input changes during RUN/DONE SHALL not affect the result.
REQ-028 clear_i = 1 SHALL force IDLE on the next edge from any state, dropping any result; clear_i SHALL take priority over both handshakes in the same cycle; in_ready_o is 0 during the clear cycle if not already in IDLE, and no handshake is taken while clear_i = 1.
REQ-029 CHUNK = WIDTH SHALL be supported: single RUN cycle, identical result to full-width add.
REQ-030 Result SHALL be bit-exact to A+B+cin (add) or A+~B+~cin (sub) modulo 2^WIDTH for all operands.

Reset
REQ-031 While rst_ni = 0: state IDLE, in_ready_o = 1, out_valid_o = 0, sum_o = 0, cout_o = 0, ovf_o = 0, chunk index 0, carry 0.
REQ-032 Reset asserted mid-RUN or mid-DONE SHALL abort immediately without producing out_valid_o after release.
REQ-033 First handshake SHALL be possible on the first rising edge after rst_ni deasserts.

Verification (WIDTH=16, CHUNK=4)
REQ-034 Add 0xFFFF + 0x0001, cin 0 -> sum 0x0000, cout 1, ovf 0, out_valid 4 cycles after acceptance edge.
REQ-035 Add 0x7FFF + 0x0001, cin 0 -> sum 0x8000, cout 0, ovf 1; sub 0x8000 - 0x0001, cin 0 -> sum 0x7FFF, cout 1, ovf 1.
REQ-036 Sub 0x0000 - 0x0000, cin 1 -> sum 0xFFFF, cout 0, ovf 0.
REQ-037 Backpressure: out_ready 0 for 3 cycles in DONE, a_i/b_i toggled -> outputs unchanged, in_ready 0, handshake on 4th cycle, in_ready 1 next cycle.
REQ-038 clear_i pulsed in 2nd RUN cycle with in_valid high -> IDLE next edge, no out_valid, no handshake that cycle; next accepted op correct.
REQ-039 rst_ni low mid-RUN -> all outputs at reset values asynchronously; random 10k-op regression vs. reference model incl. CHUNK=16 and CHUNK=1.
